ccip_batch_transmitter: RTL and testbench

Parametrised CPU-bound transmit path of the NIC. It accepts RPCs from the NIC core, buffers them in per-flow FIFOs, and writes them to host memory as batched eREQ_WRLINE_I requests on CCI-P channel 1. It generalises flow count, batch size and FIFO depth, and adds four behaviours:
- round-robin arbitration;
- almost-full backpressure;
- timeout-driven flushing of partial batches;
- drop accounting.

---
 rtl/ccip_batch_transmitter.sv | 228 ++++++++++++++++++++++
 tb/tb_ccip_batch_transmitter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_batch_transmitter.sv
// Batched CCI-P channel-1 transmit path. Per-flow FIFOs are drained by a round-robin
// IDLE/BATCH/FLUSH engine into eREQ_WRLINE_I write requests.
package ccip_batch_pkg;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_ccip_clLen;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
                            eREQ_WRFENCE = 4'h4, eREQ_INTR = 4'h6} t_ccip_c1_req;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [31:0] rpc_id;
    logic [31:0] arg;
  } RpcIf;
endpackage

module ccip_batch_transmitter
  import ccip_batch_pkg::*;
#(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 2,
  parameter int LMAX_CCIP_BATCH   = 2,
  parameter int LFLOW_DEPTH       = 3,
  parameter int LTIMEOUT          = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  t_ccip_clAddr                 tx_base_addr,
  input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
  input  logic [LTIMEOUT-1:0]          batch_timeout,
  input  logic                         start,
  input  RpcIf                         rpc_in,
  input  logic                         rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
  output logic                         ccip_tx_ready,
  input  logic                         sRx_c1TxAlmFull,
  output t_if_ccip_c1_Tx               sTx_c1,
  output logic                         pdrop_tx_flows_out,
  output logic [31:0]                  tx_drop_cnt,
  output logic [31:0]                  tx_flush_cnt,
  output logic [1:0]                   dbg_state_o
);
  localparam int MAX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;
  localparam int DEPTH     = 2 ** LFLOW_DEPTH;
  localparam logic [1:0] S_IDLE = 2'd0, S_BATCH = 2'd1, S_FLUSH = 2'd2;

  typedef logic [LFLOW_DEPTH:0]         occ_t;
  typedef logic [LFLOW_DEPTH-1:0]       ptr_t;
  typedef logic [LMAX_NUM_OF_FLOWS-1:0] flow_t;
  typedef logic [LTIMEOUT-1:0]          age_t;
  typedef logic [LMAX_CCIP_BATCH-1:0]   lb_t;

  // NIC_ID only tags simulation messages; nothing in the datapath depends on it.
  if (NIC_ID < 0) begin : g_nic_id_unused
  end

  RpcIf  mem_q [MAX_FLOWS][DEPTH];
  ptr_t  wr_ptr_q [MAX_FLOWS];
  ptr_t  rd_ptr_q [MAX_FLOWS];
  occ_t  occ_q [MAX_FLOWS];
  age_t  age_q [MAX_FLOWS];
  logic [1:0] state_q, state_d;
  flow_t rr_q, rr_d, rr_next;
  occ_t  n_q, n_d, k_q, k_d;
  logic  sel, flush_sel, pop_en, push_en, drop;
  logic [MAX_FLOWS-1:0] push_vec, pop_vec;
  lb_t   lb;
  occ_t  b_size;
  t_ccip_clLen cl_len_b;
  t_ccip_c1_ReqMemHdr pop_hdr, p1_hdr_q;
  RpcIf  p1_pay_q;
  logic  p1_valid_q, pdrop_q;
  t_if_ccip_c1_Tx tx_d, tx_q;
  logic [31:0] drop_cnt_q, flush_cnt_q;

  always_comb begin
    lb = l_tx_batch_size;
    if (int'(l_tx_batch_size) > LMAX_CCIP_BATCH) lb = lb_t'(LMAX_CCIP_BATCH);
    b_size = occ_t'(1) << lb;
    case (int'(lb))
      0:       cl_len_b = eCL_LEN_1;
      1:       cl_len_b = eCL_LEN_2;
      default: cl_len_b = eCL_LEN_4;
    endcase
  end

  // A full FIFO drops even if it is being popped in the same cycle.
  always_comb begin
    push_en = start && rpc_in_valid && (rpc_flow_id_in <= number_of_flows)
              && (occ_q[rpc_flow_id_in] != occ_t'(DEPTH));
    drop    = start && rpc_in_valid && !push_en;
    pop_en  = (state_q != S_IDLE);
    for (int f = 0; f < MAX_FLOWS; f++) begin
      push_vec[f] = push_en && (rpc_flow_id_in == flow_t'(f));
      pop_vec[f]  = pop_en && (rr_q == flow_t'(f));
    end
  end

  always_comb begin
    rr_next   = (rr_q == number_of_flows) ? '0 : rr_q + flow_t'(1);
    state_d   = state_q;
    rr_d      = rr_q;
    n_d       = n_q;
    k_d       = k_q;
    sel       = 1'b0;
    flush_sel = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sRx_c1TxAlmFull) begin
          if (occ_q[rr_q] >= b_size) begin
            state_d = S_BATCH;
            n_d     = b_size;
            k_d     = '0;
            sel     = 1'b1;
          end else if (batch_timeout != '0 && occ_q[rr_q] != '0 && age_q[rr_q] >= batch_timeout) begin
            state_d   = S_FLUSH;
            n_d       = occ_q[rr_q];
            k_d       = '0;
            sel       = 1'b1;
            flush_sel = 1'b1;
          end else begin
            rr_d = rr_next;
          end
        end
      end
      default: begin
        k_d = k_q + occ_t'(1);
        if (k_q == n_q - occ_t'(1)) begin
          state_d = S_IDLE;
          rr_d    = rr_next;
        end
      end
    endcase
  end

  always_comb begin
    pop_hdr          = '0;
    pop_hdr.req_type = eREQ_WRLINE_I;
    pop_hdr.vc_sel   = eVC_VH0;
    pop_hdr.address  = tx_base_addr + (t_ccip_clAddr'(rr_q) << lb) + t_ccip_clAddr'(k_q);
    pop_hdr.sop      = (state_q == S_FLUSH) || (k_q == '0);
    pop_hdr.cl_len   = (state_q == S_FLUSH) ? eCL_LEN_1 : cl_len_b;
    tx_d = '0;
    if (p1_valid_q) begin
      tx_d.valid                   = 1'b1;
      tx_d.hdr                     = p1_hdr_q;
      tx_d.data[$bits(RpcIf)-1:0] = p1_pay_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[rpc_flow_id_in][wr_ptr_q[rpc_flow_id_in]] <= rpc_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int f = 0; f < MAX_FLOWS; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        occ_q[f]    <= '0;
        age_q[f]    <= '0;
      end
    end else begin
      for (int f = 0; f < MAX_FLOWS; f++) begin
        if (push_vec[f]) wr_ptr_q[f] <= wr_ptr_q[f] + ptr_t'(1);
        if (pop_vec[f])  rd_ptr_q[f] <= rd_ptr_q[f] + ptr_t'(1);
        if (push_vec[f] && !pop_vec[f])      occ_q[f] <= occ_q[f] + occ_t'(1);
        else if (!push_vec[f] && pop_vec[f]) occ_q[f] <= occ_q[f] - occ_t'(1);
        if (occ_q[f] == '0 || (sel && rr_q == flow_t'(f))) age_q[f] <= '0;
        else if (age_q[f] != '1)                           age_q[f] <= age_q[f] + age_t'(1);
      end
    end
  end

  // Two-stage output: FIFO read register, then the registered CCI-P request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      n_q         <= '0;
      k_q         <= '0;
      p1_valid_q  <= 1'b0;
      p1_hdr_q    <= '0;
      p1_pay_q    <= '0;
      tx_q        <= '0;
      pdrop_q     <= 1'b0;
      drop_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      n_q        <= n_d;
      k_q        <= k_d;
      p1_valid_q <= pop_en;
      if (pop_en) begin
        p1_hdr_q <= pop_hdr;
        p1_pay_q <= mem_q[rr_q][rd_ptr_q[rr_q]];
      end
      tx_q    <= tx_d;
      pdrop_q <= drop;
      if (drop && drop_cnt_q != '1)       drop_cnt_q  <= drop_cnt_q + 32'd1;
      if (flush_sel && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign ccip_tx_ready      = ~sRx_c1TxAlmFull;
  assign sTx_c1             = tx_q;
  assign pdrop_tx_flows_out = pdrop_q;
  assign tx_drop_cnt        = drop_cnt_q;
  assign tx_flush_cnt       = flush_cnt_q;
  assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_ccip_batch_transmitter.sv
// Directed bench for ccip_batch_transmitter: table-driven batch vectors plus
// hand-written round-robin, flush, almost-full, drop and reset sequences.
module tb_ccip_batch_transmitter;
  import ccip_batch_pkg::*;

  localparam int W = 116;
  localparam logic [41:0] BASE = 42'h3_0000_1000;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [1:0]     number_of_flows;
  t_ccip_clAddr   tx_base_addr;
  logic [1:0]     l_tx_batch_size;
  logic [15:0]    batch_timeout;
  logic           start;
  RpcIf           rpc_in;
  logic           rpc_in_valid;
  logic [1:0]     rpc_flow_id_in;
  logic           ccip_tx_ready;
  logic           sRx_c1TxAlmFull;
  t_if_ccip_c1_Tx sTx_c1;
  logic           pdrop_tx_flows_out;
  logic [31:0]    tx_drop_cnt;
  logic [31:0]    tx_flush_cnt;
  logic [1:0]     dbg_state;

  ccip_batch_transmitter dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .number_of_flows    (number_of_flows),
    .tx_base_addr       (tx_base_addr),
    .l_tx_batch_size    (l_tx_batch_size),
    .batch_timeout      (batch_timeout),
    .start              (start),
    .rpc_in             (rpc_in),
    .rpc_in_valid       (rpc_in_valid),
    .rpc_flow_id_in     (rpc_flow_id_in),
    .ccip_tx_ready      (ccip_tx_ready),
    .sRx_c1TxAlmFull    (sRx_c1TxAlmFull),
    .sTx_c1             (sTx_c1),
    .pdrop_tx_flows_out (pdrop_tx_flows_out),
    .tx_drop_cnt        (tx_drop_cnt),
    .tx_flush_cnt       (tx_flush_cnt),
    .dbg_state_o        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_bad   = 0;
  int pdrop_seen = 0;
  logic [W-1:0] exp_q[$];

  always @(negedge clk) if (pdrop_tx_flows_out) pdrop_seen++;

  typedef struct {
    logic [1:0]  flow;
    logic [1:0]  lbs;
    logic [1:0]  nf;
    int          npush;
    logic [41:0] off;
    logic [1:0]  len;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic [41:0] a, input logic sop,
                                          input logic [1:0] len, input logic [63:0] d);
    return {4'h0, 2'h2, 1'b0, a, sop, len, d};
  endfunction

  function automatic logic [W-1:0] got_word();
    return {4'(sTx_c1.hdr.req_type), 2'(sTx_c1.hdr.vc_sel), |sTx_c1.data[511:64],
            sTx_c1.hdr.address, sTx_c1.hdr.sop, 2'(sTx_c1.hdr.cl_len), sTx_c1.data[63:0]};
  endfunction

  function automatic logic [63:0] pay(input int tag, input int i);
    return {32'hA5A5_0000 + 32'(tag), 32'h00C0_FFEE + 32'(i)};
  endfunction

  // driver tasks (called and returning at a negedge)
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] f, input logic [63:0] d);
    rpc_in         = RpcIf'(d);
    rpc_flow_id_in = f;
    rpc_in_valid   = 1'b1;
    @(negedge clk);
    rpc_in_valid   = 1'b0;
  endtask

  task automatic expect_burst(input string name, input int n, input int budget,
                              input bit af_mid, output int waited);
    logic [W-1:0] e;
    waited = 0;
    while (!sTx_c1.valid && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("%s_start", name), W'(sTx_c1.valid), W'(1));
    if (!sTx_c1.valid) begin
      for (int k = 0; k < n; k++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_line%0d", name, k), got_word(), e);
      check($sformatf("%s_valid%0d", name, k), W'(sTx_c1.valid), W'(1));
      if (af_mid && k == 0) sRx_c1TxAlmFull = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic quiet(input string name, input int cycles);
    int cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (sTx_c1.valid) cnt++;
    end
    check(name, W'(cnt), W'(0));
  endtask

  initial begin
    int w;
    int pd0;
    vecs[0] = '{2'd0, 2'd2, 2'd1, 4, 42'd0,  2'd3};
    vecs[1] = '{2'd1, 2'd1, 2'd3, 2, 42'd2,  2'd1};
    vecs[2] = '{2'd3, 2'd0, 2'd3, 1, 42'd3,  2'd0};
    vecs[3] = '{2'd2, 2'd3, 2'd3, 4, 42'd8,  2'd3};
    vecs[4] = '{2'd3, 2'd2, 2'd3, 4, 42'd12, 2'd3};
    vecs[5] = '{2'd1, 2'd2, 2'd1, 4, 42'd4,  2'd3};

    reset_n = 1'b0; number_of_flows = 2'd1; tx_base_addr = BASE; l_tx_batch_size = 2'd2;
    batch_timeout = 16'd0; start = 1'b1; rpc_in = '0; rpc_in_valid = 1'b0;
    rpc_flow_id_in = 2'd0; sRx_c1TxAlmFull = 1'b0;
    @(negedge clk);
    do_reset();

    // reset state
    check("rst_valid", W'(sTx_c1.valid), W'(0));
    check("rst_hdr", W'(sTx_c1.hdr), W'(0));
    check("rst_data_lo", W'(sTx_c1.data[63:0]), W'(0));
    check("rst_pdrop", W'(pdrop_tx_flows_out), W'(0));
    check("rst_drop_cnt", W'(tx_drop_cnt), W'(0));
    check("rst_flush_cnt", W'(tx_flush_cnt), W'(0));
    check("rst_ready", W'(ccip_tx_ready), W'(1));
    check("rst_state", W'(dbg_state), W'(0));

    // table-driven full batches
    foreach (vecs[v]) begin
      number_of_flows = vecs[v].nf;
      l_tx_batch_size = vecs[v].lbs;
      for (int i = 0; i < vecs[v].npush; i++) begin
        exp_q.push_back(mk_exp(BASE + vecs[v].off + 42'(i), i == 0, vecs[v].len, pay(v, i)));
        push(vecs[v].flow, pay(v, i));
      end
      expect_burst($sformatf("vec%0d", v), vecs[v].npush, 20, 1'b0, w);
      quiet($sformatf("vec%0d_after", v), 5);
    end

    // intake disabled when start=0
    start = 1'b0; l_tx_batch_size = 2'd0; number_of_flows = 2'd1;
    push(2'd0, pay(50, 0));
    quiet("start0_no_write", 10);
    check("start0_no_drop", W'(tx_drop_cnt), W'(0));
    start = 1'b1;

    // round-robin: preload flows 3,1,0 under almost-full, expect order 0,1,3
    sRx_c1TxAlmFull = 1'b1;
    do_reset();
    number_of_flows = 2'd3; l_tx_batch_size = 2'd1;
    for (int i = 0; i < 2; i++) push(2'd3, pay(63, i));
    for (int i = 0; i < 2; i++) push(2'd1, pay(61, i));
    for (int i = 0; i < 2; i++) push(2'd0, pay(60, i));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk_exp(BASE + 42'd0 + 42'(i), i == 0, 2'd1, pay(60, i)));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk_exp(BASE + 42'd2 + 42'(i), i == 0, 2'd1, pay(61, i)));
    for (int i = 0; i < 2; i++) exp_q.push_back(mk_exp(BASE + 42'd6 + 42'(i), i == 0, 2'd1, pay(63, i)));
    sRx_c1TxAlmFull = 1'b0;
    expect_burst("rr_f0", 2, 10, 1'b0, w);
    expect_burst("rr_f1", 2, 10, 1'b0, w);
    expect_burst("rr_f3", 2, 10, 1'b0, w);
    quiet("rr_after", 10);

    // almost-full hold, release latency, and no stall mid-burst
    sRx_c1TxAlmFull = 1'b1;
    do_reset();
    number_of_flows = 2'd1; l_tx_batch_size = 2'd2;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_exp(BASE + 42'(i), i == 0, 2'd3, pay(70, i)));
      push(2'd0, pay(70, i));
    end
    quiet("af_hold_no_valid", 20);
    check("af_ready_low", W'(ccip_tx_ready), W'(0));
    sRx_c1TxAlmFull = 1'b0;
    #1;
    check("af_ready_high", W'(ccip_tx_ready), W'(1));
    expect_burst("af_burst", 4, 4, 1'b1, w);
    check("af_latency", W'(w), W'(3));
    sRx_c1TxAlmFull = 1'b0;
    quiet("af_after", 10);

    // partial flush on timeout
    do_reset();
    number_of_flows = 2'd3; l_tx_batch_size = 2'd2; batch_timeout = 16'd10;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk_exp(BASE + 42'd8 + 42'(i), 1'b1, 2'd0, pay(80, i)));
      push(2'd2, pay(80, i));
    end
    quiet("flush_not_early", 7);
    expect_burst("flush", 3, 40, 1'b0, w);
    check("flush_cnt", W'(tx_flush_cnt), W'(1));
    quiet("flush_after", 10);

    // timeout disabled: partial batch never leaves
    do_reset();
    batch_timeout = 16'd0;
    for (int i = 0; i < 3; i++) push(2'd2, pay(90, i));
    quiet("no_flush_1000", 1000);
    check("no_flush_cnt", W'(tx_flush_cnt), W'(0));

    // drop on full FIFO and on out-of-range flow
    sRx_c1TxAlmFull = 1'b1;
    do_reset();
    number_of_flows = 2'd2; l_tx_batch_size = 2'd2;
    pd0 = pdrop_seen;
    for (int i = 0; i < 8; i++) push(2'd1, pay(100, i));
    check("drop_none_yet", W'(pdrop_seen - pd0), W'(0));
    push(2'd1, pay(100, 8));
    check("drop_pulse_hi", W'(pdrop_tx_flows_out), W'(1));
    check("drop_cnt1", W'(tx_drop_cnt), W'(1));
    @(negedge clk);
    check("drop_pulse_lo", W'(pdrop_tx_flows_out), W'(0));
    check("drop_pulses1", W'(pdrop_seen - pd0), W'(1));
    push(2'd3, pay(101, 0));
    @(negedge clk);
    check("drop_oor_cnt", W'(tx_drop_cnt), W'(2));
    check("drop_pulses2", W'(pdrop_seen - pd0), W'(2));
    for (int i = 0; i < 8; i++)
      exp_q.push_back(mk_exp(BASE + 42'd4 + 42'(i % 4), (i % 4) == 0, 2'd3, pay(100, i)));
    sRx_c1TxAlmFull = 1'b0;
    expect_burst("drop_drain_a", 4, 20, 1'b0, w);
    expect_burst("drop_drain_b", 4, 20, 1'b0, w);
    quiet("drop_after", 20);

    // reset mid-burst
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_exp(BASE + 42'(i), i == 0, 2'd3, pay(110, i)));
      push(2'd0, pay(110, i));
    end
    expect_burst("mid_first", 1, 20, 1'b0, w);
    check("mid_state_batch", W'(dbg_state), W'(1));
    exp_q.delete();
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", W'(sTx_c1.valid), W'(0));
    check("mid_rst_hdr", W'(sTx_c1.hdr), W'(0));
    check("mid_rst_drop_cnt", W'(tx_drop_cnt), W'(0));
    check("mid_rst_flush_cnt", W'(tx_flush_cnt), W'(0));
    check("mid_rst_state", W'(dbg_state), W'(0));
    reset_n = 1'b1;
    quiet("mid_rst_after", 30);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
